// File: rtl/rf_alu_pkg.sv
// Shared widths, select encodings and the ALU adder helper for the
// register-file / ID-EXE / ALU datapath slice.
package rf_alu_pkg;

  localparam int DW   = 16;
  localparam int AW   = 3;
  localparam int NREG = 8;

  localparam logic ALUOP_ADD = 1'b0;
  localparam logic ALUOP_SUB = 1'b1;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

  localparam logic RB_SEL_RN = 1'b0;
  localparam logic RB_SEL_RD = 1'b1;

  localparam logic OPB_SEL_REG = 1'b0;
  localparam logic OPB_SEL_IMM = 1'b1;

  localparam logic LI_SEL_LLI = 1'b0;
  localparam logic LI_SEL_LHI = 1'b1;

  typedef logic [DW-1:0] word_t;
  typedef logic [AW-1:0] raddr_t;

  // 17-bit add so the carry out falls out as the top bit
  function automatic logic [DW:0] alu_add(input word_t a, input word_t b, input logic cin);
    alu_add = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/rf_8x16.sv
// 8x16 register file: one write port, two full-width combinational read
// ports and a byte-wide debug view port. Reads never see a same-edge write.
module rf_8x16
  import rf_alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic [AW-1:0] rv_addr,
  output logic [7:0]    rv_byte
);

  word_t mem_r [NREG];

  // Register array storage with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign ra_data = mem_r[ra_addr];
  assign rb_data = mem_r[rb_addr];
  assign rv_byte = mem_r[rv_addr][7:0];

endmodule

// File: rtl/rf_plus_alu.sv
// Datapath slice: register file, ID-stage operand muxing, ID/EXE buffer
// and a 16-bit add/subtract ALU with C/Z/N flags.
module rf_plus_alu
  import rf_alu_pkg::*;
(
  input  logic          clk,
  input  logic          Reset,
  input  logic [10:0]   Ins,
  input  logic [DW-1:0] WBData,
  input  logic [DW-1:0] MEMData,
  input  logic          WBRF,
  input  logic          WBresource,
  input  logic          RBresource,
  input  logic          OprandB,
  input  logic          LI,
  input  logic          Buff_IDEXE,
  input  logic          ALUop,
  input  logic          PSW_C,
  input  logic          Flag,
  output logic [7:0]    Rm,
  output logic [7:0]    Rd,
  output logic [DW-1:0] OutR,
  output logic [DW-1:0] LI_EXE,
  output logic [DW-1:0] Sum,
  output logic          C,
  output logic          Z,
  output logic          N
);

  word_t         wdata_s;
  raddr_t        rb_addr_s;
  word_t         data_a_s;
  word_t         data_b_s;
  word_t         opb_s;
  word_t         li_s;
  word_t         a_exe_r;
  word_t         b_exe_r;
  word_t         out_r;
  word_t         li_exe_r;
  word_t         b_mod_s;
  logic          cin_s;
  logic [DW:0]   sum_full_s;

  // Write-back and port-B address selection
  always_comb begin
    wdata_s   = WBData;
    rb_addr_s = Ins[4:2];
    case (WBresource)
      WB_SEL_ALU: wdata_s = WBData;
      WB_SEL_MEM: wdata_s = MEMData;
      default:    wdata_s = WBData;
    endcase
    case (RBresource)
      RB_SEL_RN: rb_addr_s = Ins[4:2];
      RB_SEL_RD: rb_addr_s = Ins[10:8];
      default:   rb_addr_s = Ins[4:2];
    endcase
  end

  rf_8x16 u_rf (
    .clk     (clk),
    .rst_n   (Reset),
    .we      (WBRF),
    .waddr   (Ins[10:8]),
    .wdata   (wdata_s),
    .ra_addr (Ins[7:5]),
    .ra_data (data_a_s),
    .rb_addr (rb_addr_s),
    .rb_data (data_b_s),
    .rv_addr (Ins[10:8]),
    .rv_byte (Rd)
  );

  assign Rm = data_a_s[7:0];

  // ID-stage operand B and load-immediate formation
  always_comb begin
    opb_s = data_b_s;
    li_s  = {8'h00, Ins[7:0]};
    case (OprandB)
      OPB_SEL_REG: opb_s = data_b_s;
      OPB_SEL_IMM: opb_s = {{(DW-3){1'b0}}, Ins[4:2]};
      default:     opb_s = data_b_s;
    endcase
    // LHI keeps the destination's low byte, read through port B
    case (LI)
      LI_SEL_LLI: li_s = {8'h00, Ins[7:0]};
      LI_SEL_LHI: li_s = {Ins[7:0], data_b_s[7:0]};
      default:    li_s = {8'h00, Ins[7:0]};
    endcase
  end

  // ID/EXE pipeline buffer
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      a_exe_r  <= {DW{1'b0}};
      b_exe_r  <= {DW{1'b0}};
      out_r    <= {DW{1'b0}};
      li_exe_r <= {DW{1'b0}};
    end else if (Buff_IDEXE) begin
      a_exe_r  <= data_a_s;
      b_exe_r  <= opb_s;
      out_r    <= data_b_s;
      li_exe_r <= li_s;
    end
  end

  // ALU operand conditioning; subtract is A + ~B + cin
  always_comb begin
    b_mod_s = b_exe_r;
    case (ALUop)
      ALUOP_ADD: b_mod_s = b_exe_r;
      ALUOP_SUB: b_mod_s = ~b_exe_r;
      default:   b_mod_s = b_exe_r;
    endcase
    if (Flag) begin
      cin_s = PSW_C;
    end else begin
      cin_s = ALUop;
    end
  end

  assign sum_full_s = alu_add(a_exe_r, b_mod_s, cin_s);

  assign Sum    = sum_full_s[DW-1:0];
  assign C      = sum_full_s[DW];
  assign Z      = (sum_full_s[DW-1:0] == {DW{1'b0}});
  assign N      = sum_full_s[DW-1];
  assign OutR   = out_r;
  assign LI_EXE = li_exe_r;

endmodule

// File: tb/tb_rf_plus_alu.sv
// Self-checking bench for rf_plus_alu: directed scenarios plus randomized
// traffic compared against an arithmetic reference model.
module tb_rf_plus_alu;

  logic        clk = 1'b0;
  logic        Reset;
  logic [10:0] Ins;
  logic [15:0] WBData, MEMData;
  logic        WBRF, WBresource, RBresource, OprandB, LI, Buff_IDEXE;
  logic        ALUop, PSW_C, Flag;
  logic [7:0]  Rm, Rd;
  logic [15:0] OutR, LI_EXE, Sum;
  logic        C, Z, N;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] m_rf [8];
  logic [15:0] m_a, m_b, m_outr, m_li;

  rf_plus_alu dut (
    .clk(clk), .Reset(Reset), .Ins(Ins), .WBData(WBData), .MEMData(MEMData),
    .WBRF(WBRF), .WBresource(WBresource), .RBresource(RBresource),
    .OprandB(OprandB), .LI(LI), .Buff_IDEXE(Buff_IDEXE), .ALUop(ALUop),
    .PSW_C(PSW_C), .Flag(Flag), .Rm(Rm), .Rd(Rd), .OutR(OutR),
    .LI_EXE(LI_EXE), .Sum(Sum), .C(C), .Z(Z), .N(N)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 16'd0;
    m_a = 16'd0; m_b = 16'd0; m_outr = 16'd0; m_li = 16'd0;
  endtask

  // Expected ALU result from plain integer arithmetic
  task automatic exp_alu(output logic [15:0] s, output logic c);
    int cin;
    int r;
    cin = Flag ? int'(PSW_C) : int'(ALUop);
    if (ALUop) r = int'(m_a) - int'(m_b) - (1 - cin) + 65536;
    else       r = int'(m_a) + int'(m_b) + cin;
    s = r[15:0];
    c = (r > 65535);
  endtask

  task automatic check_all(input string tag);
    logic [15:0] es;
    logic        ec;
    exp_alu(es, ec);
    chk({tag, ".sum"}, Sum, es);
    chk({tag, ".c"}, {15'd0, C}, {15'd0, ec});
    chk({tag, ".z"}, {15'd0, Z}, {15'd0, (es == 16'd0)});
    chk({tag, ".n"}, {15'd0, N}, {15'd0, es[15]});
    chk({tag, ".rm"}, {8'd0, Rm}, {8'd0, m_rf[Ins[7:5]][7:0]});
    chk({tag, ".rd"}, {8'd0, Rd}, {8'd0, m_rf[Ins[10:8]][7:0]});
    chk({tag, ".outr"}, OutR, m_outr);
    chk({tag, ".li"}, LI_EXE, m_li);
  endtask

  // One clock edge; the model applies the behavioural rules to the inputs held before it
  task automatic tick();
    logic        do_wr, do_buf;
    logic [2:0]  wa;
    logic [15:0] wd, db, na, nb, no, nl;
    do_wr  = (WBRF === 1'b1);
    do_buf = (Buff_IDEXE === 1'b1);
    wa = 3'd0; wd = 16'd0; na = m_a; nb = m_b; no = m_outr; nl = m_li;
    if (do_wr) begin
      wa = Ins[10:8];
      wd = WBresource ? MEMData : WBData;
    end
    if (do_buf) begin
      db = RBresource ? m_rf[Ins[10:8]] : m_rf[Ins[4:2]];
      na = m_rf[Ins[7:5]];
      nb = OprandB ? {13'd0, Ins[4:2]} : db;
      no = db;
      nl = LI ? {Ins[7:0], db[7:0]} : {8'h00, Ins[7:0]};
    end
    @(posedge clk);
    #1;
    if (do_wr) m_rf[wa] = wd;
    m_a = na; m_b = nb; m_outr = no; m_li = nl;
  endtask

  task automatic drive(input logic [10:0] ins, input logic [15:0] wbd, input logic [15:0] memd,
                       input logic wbrf, input logic wbsrc, input logic rbsrc,
                       input logic opb, input logic li, input logic buff);
    Ins = ins; WBData = wbd; MEMData = memd; WBRF = wbrf; WBresource = wbsrc;
    RBresource = rbsrc; OprandB = opb; LI = li; Buff_IDEXE = buff;
  endtask

  task automatic set_alu(input logic op, input logic flg, input logic psw);
    ALUop = op; Flag = flg; PSW_C = psw;
  endtask

  task automatic rebuf(input logic [2:0] r, input logic op, input logic flg, input logic psw);
    drive({r, r, r, 2'b00}, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    set_alu(op, flg, psw);
    #1;
    check_all("rebuf");
  endtask

  initial begin
    logic [2:0] r3;
    logic [15:0] hs, ho, hl;
    Reset = 1'b0;
    drive(11'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_alu(1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    Reset = 1'b1;
    #1;
    chk("rst.sum", Sum, 16'd0);
    chk("rst.z", {15'd0, Z}, 16'd1);
    chk("rst.c", {15'd0, C}, 16'd0);
    check_all("rst");

    for (int i = 0; i < 8; i++) begin
      r3 = i[2:0];
      drive({r3, r3, r3, 2'b00}, 16'(i + 1), 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      check_all("wr");
      tick();
    end

    rebuf(3'd1, 1'b0, 1'b0, 1'b0);
    chk("add.sum", Sum, 16'd4);
    chk("add.c", {15'd0, C}, 16'd0);
    rebuf(3'd2, 1'b1, 1'b0, 1'b0);
    chk("sub.sum", Sum, 16'd0);
    chk("sub.z", {15'd0, Z}, 16'd1);
    chk("sub.c", {15'd0, C}, 16'd1);
    rebuf(3'd3, 1'b1, 1'b1, 1'b0);
    chk("sbb.sum", Sum, 16'hFFFF);
    chk("sbb.n", {15'd0, N}, 16'd1);
    chk("sbb.c", {15'd0, C}, 16'd0);
    rebuf(3'd5, 1'b0, 1'b1, 1'b1);
    chk("adc.sum", Sum, 16'd13);

    // R0 cleared, then written and buffered on the same edge
    set_alu(1'b0, 1'b0, 1'b0);
    drive(11'd0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(11'd0, 16'd1, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk("nobyp.sum", Sum, 16'd0);
    drive(11'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk("nobyp2.sum", Sum, 16'd1);
    check_all("nobyp2");

    drive({3'd1, 8'h55}, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    chk("lhi", LI_EXE, 16'h5502);
    drive({3'd1, 8'h44}, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("lli", LI_EXE, 16'h0044);

    drive({3'd1, 8'h00}, 16'hBEEF, 16'h1100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("ldr.rd", {8'd0, Rd}, 16'h0000);
    drive({3'd1, 8'h00}, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("ldr.outr", OutR, 16'h1100);
    check_all("ldr");

    drive({3'd0, 3'd6, 3'd5, 2'b00}, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    set_alu(1'b1, 1'b0, 1'b0);
    #1;
    chk("imm.sum", Sum, 16'd2);
    chk("imm.c", {15'd0, C}, 16'd1);

    hs = Sum; ho = OutR; hl = LI_EXE;
    drive('x, 'x, 'x, 1'b0, 1'bx, 1'bx, 1'bx, 1'bx, 1'b0);
    tick();
    tick();
    chk("hold.sum", Sum, hs);
    chk("hold.outr", OutR, ho);
    chk("hold.li", LI_EXE, hl);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      drive(11'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
      set_alu(1'($urandom), 1'($urandom), 1'($urandom));
      #1;
      check_all("rnd");
      tick();
    end

    // Reset mid-operation beats a simultaneous write and buffer load
    drive({3'd2, 8'hA5}, 16'h1234, 16'h5678, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    set_alu(1'b0, 1'b0, 1'b0);
    Reset = 1'b0;
    model_reset();
    #1;
    check_all("arst");
    @(posedge clk);
    #1;
    check_all("arst_edge");
    Reset = 1'b1;
    drive(11'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("arst.z", {15'd0, Z}, 16'd1);
    check_all("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_plus_alu.md
Name: rf_plus_alu

Overview:
Datapath slice of the multicycle RISC core. It contains an 8x16 register file with one write port and three read ports, and the ID-stage operand muxing. It also holds the ID/EXE pipeline buffer and a 16-bit add/subtract ALU with C/Z/N flags. The controller drives all select and enable inputs; the PSW register lives outside this block.

Parameters:
DW, 16, datapath/register width
NREG, 8, number of registers (address width 3)

Ports:
clk  in  1  rising-edge clock
Reset  in  1  asynchronous, active-low reset
Ins  in  11  instruction field: [10:8]=Rd addr, [7:5]=Rm addr, [4:2]=Rn addr, [7:0]=imm8
WBData  in  16  ALU/other write-back data
MEMData  in  16  memory load data
WBRF  in  1  register-file write enable
WBresource  in  1  write-data select: 0=WBData, 1=MEMData
RBresource  in  1  read-port-B address select: 0=Ins[4:2], 1=Ins[10:8]
OprandB  in  1  ALU operand B select: 0=port-B data, 1=zero-extended Ins[4:2]
LI  in  1  load-immediate form: 1=LHI, 0=LLI
Buff_IDEXE  in  1  ID/EXE buffer load enable
ALUop  in  1  0=add, 1=subtract (EXE stage)
PSW_C  in  1  stored carry flag from PSW
Flag  in  1  1=use PSW_C as carry/borrow input
Rm  out  8  RF[Ins[7:5]][7:0], combinational (ID debug/address view)
Rd  out  8  RF[Ins[10:8]][7:0], combinational
OutR  out  16  buffered port-B register data (store data)
LI_EXE  out  16  buffered load-immediate result
Sum  out  16  ALU result
C  out  1  ALU carry out (no-borrow on subtract)
Z  out  1  Sum==0
N  out  1  Sum[15]

Behaviour:
- Register file: 8x16 flops; R0 is an ordinary writable register.
- Write: at posedge clk when WBRF=1, RF[Ins[10:8]] <= (WBresource ? MEMData : WBData).
- Reads are combinational with no write-to-read bypass. A read at the same edge as a write returns the old value.
- Port A address is Ins[7:5]. Port B address is RBresource ? Ins[10:8] : Ins[4:2].
- ID-stage values:
  - opB = OprandB ? {13'b0, Ins[4:2]} : DataB.
  - li = LI ? {Ins[7:0], DataB[7:0]} : {8'h00, Ins[7:0]}.
- ID/EXE buffer: at posedge clk when Buff_IDEXE=1, load A_EXE<=DataA, B_EXE<=opB, OutR<=DataB, LI_EXE<=li. When Buff_IDEXE=0, hold.
- ALU (combinational on the buffer):
  - cin = Flag ? PSW_C : ALUop.
  - {C, Sum} = A_EXE + (ALUop ? ~B_EXE : B_EXE) + cin, computed 17 bits wide.
  - Resulting operations: add, add-with-carry, subtract, and subtract-with-borrow (A - B - ~PSW_C).
  - Z = (Sum==16'h0). N = Sum[15].
  - ALUop, PSW_C and Flag act in the same cycle; they are not buffered.
- Reset (Reset=0, async): all RF entries, A_EXE, B_EXE, OutR and LI_EXE go to 0. Resulting outputs: Sum=0, Z=1, N=0, C=0 (with ALUop=0, Flag=0).
- Reset asserted mid-operation overrides any simultaneous write or buffer load.
- X on Ins/WBData/MEMData is permitted while WBRF=0 and Buff_IDEXE=0. In that case state must not change.

Decomposition:
- Package rf_alu_pkg holds:
  - DW and address width (3);
  - ALUOP_ADD=1'b0 and ALUOP_SUB=1'b1;
  - select encodings for WBresource, RBresource, OprandB and LI.
- One sub-module, rf_8x16: write port plus two combinational read ports, async active-low clear.
- Operand muxes, ID/EXE buffer and ALU stay in the top level.

Test Plan:
- Reset low for 3 cycles, then release -> all outputs 0 except Z=1; Rm=Rd=0.
- For i=0..7, write WBData=i+1 to Ri (WBRF=1, WBresource=0) with Rd=Rm=Rn=i and Buff_IDEXE=1 on the same edge. Then re-buffer with no write:
  - i=1, ALUop=0, Flag=0: Sum=4, C=0.
  - i=2, ALUop=1, Flag=0: Sum=0, Z=1, C=1.
  - i=3, ALUop=1, Flag=1, PSW_C=0: Sum=16'hFFFF, N=1, C=0.
  - i=5, ALUop=0, Flag=1, PSW_C=1: Sum=13.
- Same-edge write and buffer of R0 (value 1, old value 0) -> buffered A reflects 0 (no bypass); the next buffer load gives 1.
- LHI: R1=2, Ins={3'd1,8'h55}, RBresource=1, LI=1, Buff_IDEXE=1 -> LI_EXE=16'h5502.
- LLI: Ins={3'd1,8'h44}, LI=0, Buff_IDEXE=1 -> LI_EXE=16'h0044.
- LDR: WBRF=1, WBresource=1, MEMData=16'h1100, Rd addr 1 -> next cycle Rd=8'h00. A following buffer with RBresource=1 gives OutR=16'h1100. WBData is ignored.
- OprandB=1, Ins[4:2]=3'd5, R(Rm)=7, ALUop=1 -> Sum=2, C=1.
- Buff_IDEXE=0 with X inputs -> Sum, OutR and LI_EXE unchanged.
